// File: rtl/rpn_stack_ctrl_if.sv
// -----------------------------------------------------------------------------
// rpn_stack_ctrl_if
// Command/response channel between the switch/key front end (master) and the
// RPN stack controller (slave).
//   cmd_valid   : command present, held by the master until accepted
//   cmd_ready   : controller idle and able to accept
//   cmd_op      : 000 PUSH, 001 POP, 010 OPERATE, 011 CLEAR, 100 DUP/illegal
//   cmd_data    : PUSH operand
//   cmd_alu_sel : ALU opcode, meaningful for OPERATE only
//   rsp_valid   : one-cycle pulse when the command has finished
//   rsp_error   : qualifies rsp_valid, command rejected
//   err_code    : 00 none, 01 underflow, 10 overflow, 11 illegal
// -----------------------------------------------------------------------------
interface rpn_stack_ctrl_if #(
  parameter int DATA_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic [DATA_W-1:0] cmd_data;
  logic [2:0]        cmd_alu_sel;
  logic              rsp_valid;
  logic              rsp_error;
  logic [1:0]        err_code;

  modport master (
    output cmd_valid, cmd_op, cmd_data, cmd_alu_sel,
    input  cmd_ready, rsp_valid, rsp_error, err_code
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, cmd_alu_sel,
    output cmd_ready, rsp_valid, rsp_error, err_code
  );
endinterface

// File: rtl/rpn_stack_ctrl.sv
// -----------------------------------------------------------------------------
// rpn_stack_ctrl
// Sequencer for the RPN calculator datapath. Owns the stack pointer, drives the
// stack RAM (synchronous, 1-cycle read latency), pulses the A/B operand
// register load enables and writes ALU results back onto the stack.
//
// Ports:
//   CLOCK_50   : system clock, all state on the rising edge
//   reset      : synchronous, active-high
//   cmd        : command/response channel (rpn_stack_ctrl_if.slave)
//   mem_addr/mem_data/mem_wren : stack RAM port (address 0 when unused)
//   mem_q      : stack RAM read data, valid one cycle after the address
//   a_en/b_en  : operand register load enables (registers load from mem_q)
//   alu_sel    : ALU opcode, held from one OPERATE accept to the next
//   alu_result : combinational ALU output
//   top/depth/empty/full : stack status, top reads 0 when empty
//
// Build option: define RPN_DUP_EN to enable cmd_op 100 = DUP; otherwise that
// opcode is rejected as illegal.
// -----------------------------------------------------------------------------
module rpn_stack_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  rpn_stack_ctrl_if.slave   cmd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q,
  output logic              a_en,
  output logic              b_en,
  output logic [2:0]        alu_sel,
  input  logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] top,
  output logic [ADDR_W:0]   depth,
  output logic              empty,
  output logic              full
);

  localparam logic [2:0] OP_PUSH  = 3'b000;
  localparam logic [2:0] OP_POP   = 3'b001;
  localparam logic [2:0] OP_OPER  = 3'b010;
  localparam logic [2:0] OP_CLEAR = 3'b011;
  localparam logic [2:0] OP_DUP   = 3'b100;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_UNDER = 2'b01;
  localparam logic [1:0] ERR_OVER  = 2'b10;
  localparam logic [1:0] ERR_ILL   = 2'b11;

  localparam logic [3:0] ST_IDLE    = 4'd0;
  localparam logic [3:0] ST_PUSH_WR = 4'd1;
  localparam logic [3:0] ST_POP_RD  = 4'd2;
  localparam logic [3:0] ST_POP_LD  = 4'd3;
  localparam logic [3:0] ST_OP_RDB  = 4'd4;
  localparam logic [3:0] ST_OP_LDB  = 4'd5;
  localparam logic [3:0] ST_OP_RDA  = 4'd6;
  localparam logic [3:0] ST_OP_LDA  = 4'd7;
  localparam logic [3:0] ST_OP_EXEC = 4'd8;
  localparam logic [3:0] ST_OP_WR   = 4'd9;
  localparam logic [3:0] ST_RSP     = 4'd10;
  localparam logic [3:0] ST_ERR     = 4'd11;
  localparam logic [3:0] ST_DUP_WR  = 4'd12;

  localparam logic [ADDR_W:0] DEPTH_MAX = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE       = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] TWO       = (ADDR_W+1)'(2);

  logic [3:0]        state;
  logic [ADDR_W:0]   depth_q;
  logic [DATA_W-1:0] top_q;
  logic [DATA_W-1:0] data_q;
  logic [2:0]        alu_sel_q;
  logic [1:0]        err_q;

  logic [3:0]        acc_state;
  logic [1:0]        acc_err;
  logic [ADDR_W:0]   depth_m1;
  logic [ADDR_W:0]   depth_m2;

  assign empty    = (depth_q == '0);
  assign full     = (depth_q == DEPTH_MAX);
  assign depth    = depth_q;
  assign top      = top_q;
  assign alu_sel  = alu_sel_q;
  assign depth_m1 = depth_q - ONE;
  assign depth_m2 = depth_q - TWO;

  // Bounds checks happen at accept so every later address computation is exact.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first; a path
    // that leaves one unassigned would infer a latch.
    acc_err   = ERR_NONE;
    acc_state = ST_IDLE;
    case (cmd.cmd_op)
      OP_PUSH:  if (full)         acc_err = ERR_OVER;  else acc_state = ST_PUSH_WR;
      OP_POP:   if (empty)        acc_err = ERR_UNDER; else acc_state = ST_POP_RD;
      OP_OPER:  if (depth_q < TWO) acc_err = ERR_UNDER; else acc_state = ST_OP_RDB;
      OP_CLEAR: acc_state = ST_RSP;
`ifdef RPN_DUP_EN
      OP_DUP: begin
        if (empty)     acc_err   = ERR_UNDER;
        else if (full) acc_err   = ERR_OVER;
        else           acc_state = ST_DUP_WR;
      end
`endif
      default:  acc_err = ERR_ILL;
    endcase
    if (acc_err != ERR_NONE) acc_state = ST_ERR;
  end

  always_ff @(posedge CLOCK_50) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (reset) begin
      state     <= ST_IDLE;
      depth_q   <= '0;
      top_q     <= '0;
      data_q    <= '0;
      alu_sel_q <= '0;
      err_q     <= ERR_NONE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd.cmd_valid) begin
            state  <= acc_state;
            err_q  <= acc_err;
            data_q <= cmd.cmd_data;
            if (cmd.cmd_op == OP_OPER) alu_sel_q <= cmd.cmd_alu_sel;
            if (cmd.cmd_op == OP_CLEAR) begin
              depth_q <= '0;
              top_q   <= '0;
            end
          end
        end
        ST_PUSH_WR: begin
          depth_q <= depth_q + ONE;
          top_q   <= data_q;
          state   <= ST_RSP;
        end
        ST_DUP_WR: begin
          depth_q <= depth_q + ONE;
          state   <= ST_RSP;
        end
        ST_POP_RD: begin
          depth_q <= depth_m1;
          // Popping the last word leaves nothing to read back.
          if (depth_q == ONE) begin
            top_q <= '0;
            state <= ST_RSP;
          end else begin
            state <= ST_POP_LD;
          end
        end
        ST_POP_LD: begin
          top_q <= mem_q;
          state <= ST_RSP;
        end
        ST_OP_RDB:  state <= ST_OP_LDB;
        ST_OP_LDB:  state <= ST_OP_RDA;
        ST_OP_RDA:  state <= ST_OP_LDA;
        ST_OP_LDA:  state <= ST_OP_EXEC;
        ST_OP_EXEC: state <= ST_OP_WR;
        ST_OP_WR: begin
          top_q   <= alu_result;
          depth_q <= depth_m1;
          state   <= ST_RSP;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Datapath strobes are decoded straight from the state, so each is a single
  // cycle and no two can coincide.
  always_comb begin
    mem_addr = '0;
    mem_data = '0;
    mem_wren = 1'b0;
    a_en     = (state == ST_OP_LDA);
    b_en     = (state == ST_OP_LDB);
    case (state)
      ST_PUSH_WR: begin
        mem_addr = depth_q[ADDR_W-1:0];
        mem_data = data_q;
        mem_wren = 1'b1;
      end
      ST_DUP_WR: begin
        mem_addr = depth_q[ADDR_W-1:0];
        mem_data = top_q;
        mem_wren = 1'b1;
      end
      // Fetch the word that becomes the new top once depth drops by one.
      ST_POP_RD: if (depth_q >= TWO) mem_addr = depth_m2[ADDR_W-1:0];
      ST_OP_RDB: mem_addr = depth_m1[ADDR_W-1:0];
      ST_OP_RDA: mem_addr = depth_m2[ADDR_W-1:0];
      ST_OP_WR: begin
        mem_addr = depth_m2[ADDR_W-1:0];
        mem_data = alu_result;
        mem_wren = 1'b1;
      end
      default: ;
    endcase
  end

  assign cmd.cmd_ready = (state == ST_IDLE);
  assign cmd.rsp_valid = (state == ST_RSP) || (state == ST_ERR);
  assign cmd.rsp_error = (state == ST_ERR);
  assign cmd.err_code  = (state == ST_ERR) ? err_q : ERR_NONE;

endmodule

// File: tb/tb_rpn_stack_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rpn_stack_ctrl
// Drives rpn_stack_ctrl with directed and random commands. A small RAM and a
// stand-in ALU with A/B registers surround the controller; a queue-based stack
// model predicts response timing, errors, RAM writes and stack status.
// A two-word stack with a 1-bit address keeps full/empty boundaries frequent.
// -----------------------------------------------------------------------------
module tb_rpn_stack_ctrl;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 1;
  localparam int DEPTH  = 2;
`ifdef RPN_DUP_EN
  localparam bit DUP_EN = 1'b1;
`else
  localparam bit DUP_EN = 1'b0;
`endif

  logic              CLOCK_50 = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_wren;
  logic [DATA_W-1:0] mem_q;
  logic              a_en, b_en;
  logic [2:0]        alu_sel;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] top;
  logic [ADDR_W:0]   depth;
  logic              empty, full;

  rpn_stack_ctrl_if #(.DATA_W(DATA_W)) cmd_if ();

  rpn_stack_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .cmd        (cmd_if),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_wren   (mem_wren),
    .mem_q      (mem_q),
    .a_en       (a_en),
    .b_en       (b_en),
    .alu_sel    (alu_sel),
    .alu_result (alu_result),
    .top        (top),
    .depth      (depth),
    .empty      (empty),
    .full       (full)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  // Datapath surroundings: synchronous RAM and operand registers.
  logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] a_reg, b_reg;

  always @(posedge CLOCK_50) begin
    if (mem_wren) ram[mem_addr] <= mem_data;
    mem_q <= ram[mem_addr];
    if (a_en) a_reg <= mem_q;
    if (b_en) b_reg <= mem_q;
  end

  function automatic logic [DATA_W-1:0] alu_f(input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b,
                                              input logic [2:0] sel);
    case (sel)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return a;
      3'd6:    return b;
      default: return ~(a & b);
    endcase
  endfunction

  assign alu_result = alu_f(a_reg, b_reg, alu_sel);

  int n_total = 0;
  int n_bad   = 0;
  int overlap = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference stack model.
  logic [DATA_W-1:0] mq[$];
  logic [2:0]        m_sel = 3'd0;

  function automatic logic [31:0] model_top();
    return (mq.size() == 0) ? 32'd0 : 32'(mq[mq.size()-1]);
  endfunction

  task automatic count_strobes();
    if ((int'(mem_wren) + int'(a_en) + int'(b_en) + int'(cmd_if.rsp_valid)) > 1) overlap++;
  endtask

  task automatic do_cmd(input logic [2:0] op, input logic [DATA_W-1:0] data,
                        input logic [2:0] sel);
    int n, exp_lat, exp_wr_lat, cyc, wr_cnt, wr_lat, w;
    logic [1:0]        exp_err;
    logic [31:0]       exp_wr_addr;
    logic [DATA_W-1:0] exp_wr_data, a, b, r;
    logic [31:0]       wr_addr;
    logic [DATA_W-1:0] wr_data;
    bit                exp_wr, got_rsp;
    n = mq.size();
    exp_err = 2'b00; exp_lat = 0; exp_wr = 0; exp_wr_lat = 0;
    exp_wr_addr = 0; exp_wr_data = '0;
    if (op >= 3'd5 || (op == 3'd4 && !DUP_EN)) exp_err = 2'b11;
    else begin
      case (op)
        3'd0: if (n == DEPTH) exp_err = 2'b10;
              else begin
                exp_lat = 2; exp_wr = 1; exp_wr_lat = 1;
                exp_wr_addr = 32'(n); exp_wr_data = data; mq.push_back(data);
              end
        3'd1: if (n == 0) exp_err = 2'b01;
              else begin
                void'(mq.pop_back());
                exp_lat = (mq.size() == 0) ? 2 : 3;
              end
        3'd2: begin
                m_sel = sel;
                if (n < 2) exp_err = 2'b01;
                else begin
                  b = mq.pop_back(); a = mq.pop_back(); r = alu_f(a, b, sel);
                  mq.push_back(r);
                  exp_lat = 7; exp_wr = 1; exp_wr_lat = 6;
                  exp_wr_addr = 32'(n - 2); exp_wr_data = r;
                end
              end
        3'd3: begin mq.delete(); exp_lat = 1; end
        default: if (n == 0) exp_err = 2'b01;
              else if (n == DEPTH) exp_err = 2'b10;
              else begin
                exp_lat = 2; exp_wr = 1; exp_wr_lat = 1;
                exp_wr_addr = 32'(n); exp_wr_data = mq[n-1]; mq.push_back(mq[n-1]);
              end
      endcase
    end
    if (exp_err != 2'b00) exp_lat = 1;

    w = 0;
    while (!cmd_if.cmd_ready && w < 20) begin @(negedge CLOCK_50); w++; end
    check("cmd_ready", 32'(cmd_if.cmd_ready), 32'd1);
    cmd_if.cmd_valid   = 1'b1;
    cmd_if.cmd_op      = op;
    cmd_if.cmd_data    = data;
    cmd_if.cmd_alu_sel = sel;
    @(negedge CLOCK_50);
    cmd_if.cmd_valid   = 1'b0;
    cyc = 1; wr_cnt = 0; wr_lat = 0; wr_addr = 0; wr_data = '0; got_rsp = 0;
    while (cyc <= 20) begin
      count_strobes();
      if (mem_wren) begin
        wr_cnt++; wr_lat = cyc; wr_addr = 32'(mem_addr); wr_data = mem_data;
      end
      if (cmd_if.rsp_valid) begin got_rsp = 1; break; end
      @(negedge CLOCK_50);
      cyc++;
    end
    check("rsp_seen", 32'(got_rsp), 32'd1);
    check("rsp_latency", 32'(cyc), 32'(exp_lat));
    check("rsp_error", 32'(cmd_if.rsp_error), 32'(exp_err != 2'b00));
    check("err_code", 32'(cmd_if.err_code), 32'(exp_err));
    check("wr_count", 32'(wr_cnt), 32'(exp_wr));
    if (exp_wr) begin
      check("wr_cycle", 32'(wr_lat), 32'(exp_wr_lat));
      check("wr_addr", wr_addr, exp_wr_addr);
      check("wr_data", 32'(wr_data), 32'(exp_wr_data));
    end
    check("depth", 32'(depth), 32'(mq.size()));
    check("top", 32'(top), model_top());
    check("empty", 32'(empty), 32'(mq.size() == 0));
    check("full", 32'(full), 32'(mq.size() == DEPTH));
    check("alu_sel", 32'(alu_sel), 32'(m_sel));
    @(negedge CLOCK_50);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_ready"}, 32'(cmd_if.cmd_ready), 32'd1);
    check({tag, "_depth"}, 32'(depth), 32'd0);
    check({tag, "_top"}, 32'(top), 32'd0);
    check({tag, "_empty"}, 32'(empty), 32'd1);
    check({tag, "_alu_sel"}, 32'(alu_sel), 32'd0);
    check({tag, "_strobes"}, {28'd0, mem_wren, a_en, b_en, cmd_if.rsp_valid}, 32'd0);
    check({tag, "_err_code"}, 32'(cmd_if.err_code), 32'd0);
  endtask

  initial begin
    int cyc, p;
    reset = 1'b1;
    cmd_if.cmd_valid = 1'b0; cmd_if.cmd_op = 3'd0;
    cmd_if.cmd_data = '0; cmd_if.cmd_alu_sel = 3'd0;
    repeat (3) @(negedge CLOCK_50);
    reset = 1'b0;
    check_reset_state("reset");

    // Directed scenarios.
    do_cmd(3'd0, 8'h05, 3'd0);
    check("plan_push_top", 32'(top), 32'h05);
    do_cmd(3'd3, 8'h00, 3'd0);
    do_cmd(3'd0, 8'h03, 3'd0);
    do_cmd(3'd0, 8'h04, 3'd0);
    do_cmd(3'd2, 8'h00, 3'd0);
    check("plan_add_top", 32'(top), 32'h07);
    do_cmd(3'd1, 8'h00, 3'd0);
    do_cmd(3'd1, 8'h00, 3'd0);
    do_cmd(3'd2, 8'h00, 3'd1);
    do_cmd(3'd0, 8'h01, 3'd0);
    do_cmd(3'd2, 8'h00, 3'd2);
    do_cmd(3'd0, 8'h02, 3'd0);
    do_cmd(3'd0, 8'h03, 3'd0);
    check("plan_ovf_top", 32'(top), 32'h02);
    do_cmd(3'd3, 8'h00, 3'd0);
    do_cmd(3'd0, 8'h0A, 3'd0);
    do_cmd(3'd0, 8'h0B, 3'd0);
    do_cmd(3'd1, 8'h00, 3'd0);
    check("plan_pop_top", 32'(top), 32'h0A);
    do_cmd(3'd4, 8'h00, 3'd0);
    do_cmd(3'd5, 8'h00, 3'd0);
    do_cmd(3'd7, 8'h00, 3'd0);
    do_cmd(3'd3, 8'h00, 3'd0);

    // Reset while the A operand is being loaded abandons the OPERATE.
    do_cmd(3'd0, 8'h21, 3'd0);
    do_cmd(3'd0, 8'h13, 3'd0);
    cmd_if.cmd_valid = 1'b1; cmd_if.cmd_op = 3'd2; cmd_if.cmd_alu_sel = 3'd4;
    @(negedge CLOCK_50);
    cmd_if.cmd_valid = 1'b0;
    cyc = 1;
    while (!a_en && cyc < 10) begin count_strobes(); @(negedge CLOCK_50); cyc++; end
    check("lda_cycle", 32'(cyc), 32'd4);
    reset = 1'b1;
    @(negedge CLOCK_50);
    reset = 1'b0;
    mq.delete(); m_sel = 3'd0;
    check_reset_state("mid_reset");
    @(negedge CLOCK_50);
    check("mid_reset_no_wr", 32'(mem_wren), 32'd0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      logic [2:0] op;
      p = int'($urandom_range(0, 99));
      if (p < 35)      op = 3'd0;
      else if (p < 58) op = 3'd1;
      else if (p < 80) op = 3'd2;
      else if (p < 85) op = 3'd3;
      else if (p < 93) op = 3'd4;
      else             op = 3'(5 + $urandom_range(0, 2));
      do_cmd(op, 8'($urandom), 3'($urandom));
    end

    check("strobe_overlap", 32'(overlap), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/rpn_stack_ctrl.md
Name: rpn_stack_ctrl

Overview:
Command-driven sequencer for the RPN calculator datapath: the stack RAM, the A/B operand registers and the ALU.
- Accepts PUSH / POP / OPERATE / CLEAR commands over a valid/ready handshake.
- Owns the stack pointer.
- Drives the RAM port, which is synchronous with 1-cycle read latency.
- Pulses the A/B register load enables and writes ALU results back to the stack.
- Detects underflow, overflow and illegal commands.
- Sits between the switch/key front end and the stack/ALU/register instances.

Parameters:
DATA_W, 8, stack word and ALU operand width
ADDR_W, 8, stack RAM address width
DEPTH, 256, stack capacity in words; legal range 2..2**ADDR_W

Ports:
CLOCK_50  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  controller can accept a command; high only in IDLE
cmd_op  input  3  000 PUSH, 001 POP, 010 OPERATE, 011 CLEAR, 100 DUP (see Optional Feature), others illegal
cmd_data  input  DATA_W  PUSH operand
cmd_alu_sel  input  3  ALU opcode for OPERATE; captured at accept
mem_addr  output  ADDR_W  stack RAM address
mem_data  output  DATA_W  stack RAM write data
mem_wren  output  1  stack RAM write enable
mem_q  input  DATA_W  stack RAM read data, valid 1 cycle after address
a_en  output  1  A operand register load enable (loads from mem_q)
b_en  output  1  B operand register load enable (loads from mem_q)
alu_sel  output  3  ALU opcode, held from accept until the next accept
alu_result  input  DATA_W  combinational ALU output
rsp_valid  output  1  one-cycle pulse: command finished
rsp_error  output  1  qualifies rsp_valid; command rejected
err_code  output  2  00 none, 01 underflow, 10 overflow, 11 illegal; valid with rsp_valid
top  output  DATA_W  current top-of-stack value; 0 when empty
depth  output  ADDR_W+1  number of stacked words
empty, full  output  1  depth==0 / depth==DEPTH

Behaviour:
- Stack layout: words at addresses 0..depth-1; top at depth-1.
- Reset (any state, any cycle): state IDLE, depth=0, top=0, alu_sel=0, all strobes 0, err_code=0, cmd_ready=1 the following cycle. A command in flight is abandoned; RAM contents are don't-care.
- Accept: cmd_valid && cmd_ready in IDLE.
  - cmd_op and cmd_data are captured on accept.
  - cmd_alu_sel is captured on OPERATE accept only.
  - cmd_ready drops the next cycle.
- mem_wren, a_en, b_en and rsp_valid are single-cycle and never overlap.
- mem_addr is 0 when unused.
- Checks at accept, in priority order:
  1. Illegal op → err 11.
  2. PUSH with full → err 10.
  3. POP with empty → err 01.
  4. OPERATE with depth<2 → err 01.
- Any error: rsp_valid=rsp_error=1 the cycle after accept; no RAM write; depth and top unchanged.
- States and actions:
  - IDLE: wait for accept.
  - PUSH_WR: mem_addr=depth, mem_data=cmd_data, mem_wren=1; depth+1; top=cmd_data. rsp_valid next cycle (2 cycles after accept).
  - POP_RD: depth-1.
    - If new depth is 0: top=0, go to RSP.
    - Else mem_addr=new depth-1, then POP_LD: top=mem_q, go to RSP.
  - OP_RDB: mem_addr=depth-1.
  - OP_LDB: b_en=1.
  - OP_RDA: mem_addr=depth-2.
  - OP_LDA: a_en=1.
  - OP_EXEC: operand registers settle; ALU output is valid.
  - OP_WR: mem_addr=depth-2, mem_data=alu_result, mem_wren=1; top=alu_result; depth-1.
  - RSP: rsp_valid=1, rsp_error=0, err_code=00; return to IDLE.
  - OPERATE latency: accept to rsp_valid = 7 cycles.
  - CLEAR: depth=0, top=0, no RAM access; rsp_valid next cycle.
- Arithmetic:
  - alu_result is truncated to DATA_W; no carry or overflow reporting.
  - B is the top operand and A the one below, so the result is A op B.
  - Address arithmetic is exact; no wrap, because bounds are checked first.
- cmd_valid while busy is ignored. The requester must hold cmd_valid until accepted.

Optional Feature:
Macro RPN_DUP_EN.
- Defined: cmd_op 100 = DUP.
  - Errors: empty → err 01; full → err 10.
  - Else DUP_WR: mem_addr=depth, mem_data=top, mem_wren=1; depth+1; top unchanged; rsp_valid next cycle.
- Undefined: cmd_op 100 is illegal → err 11.

Test Plan:
- Reset, then PUSH 8'h05 → mem_wren at addr 0 data 05 one cycle after accept; rsp_valid two cycles after accept; depth=1, top=05.
- PUSH 03, PUSH 04, OPERATE alu_sel=000 (bench ALU model: add) → b_en loads 04, a_en loads 03, write 07 at addr 0; depth=1, top=07; rsp_valid 7 cycles after accept.
- From reset, POP → rsp_error=1, err_code=01, depth=0, no mem_wren; then OPERATE with depth=1 → err 01.
- DEPTH=2, three PUSHes → third gets err_code=10, depth=2, top=second value.
- PUSH 0A, PUSH 0B, POP → top=0A, depth=1; CLEAR → depth=0, top=0, empty=1.
- Assert reset during OP_LDA → next cycle IDLE, depth=0, no mem_wren. cmd_op=100 → err 11 without RPN_DUP_EN; with it, DUP of 0A gives depth 2 and write of 0A at addr 1.
